s2a_burst_sched: RTL and testbench
==================================

# s2a_burst_sched

Stream-side scheduler that lets two sample streams share one stream-to-AXI burst writer. Sits in the Sclk domain between the stream sources and the burst engine. For each channel it:
- tracks the ring-buffer write position;
- produces the local 32-word ping-pong buffer address;
- turns each completed 16-word line into a burst descriptor.

A round-robin arbiter presents one descriptor at a time to the writer over a valid/ready handshake.

## Interface
Parameters:
- none (geometry fixed: 16 words/line, 64-byte lines, 2 lines per channel buffer)

Ports:
- Sclk  in  1  stream clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- sync  in  1  synchronous clear of both channels' counters, pending requests and arbiter pointer
- ien0 / ien1  in  1  per-channel sample write strobe, one word per cycle
- base0 / base1  in  32  ring base byte address; bits [5:0] ignored
- size0 / size1  in  18  ring size in 64-byte lines (byte bits [23:6])
- iaddr0 / iaddr1  out  5  buffer write address = cnt[4:0] of channel
- iacnt0 / iacnt1  out  18  current line index
- bcnt0 / bcnt1  out  32  completed ring wraps
- desc_valid  out  1  descriptor available
- desc_ready  in  1  writer accepts descriptor
- desc_addr  out  32  burst byte address, [5:0]=0
- desc_ch  out  1  channel of descriptor
- desc_half  out  1  buffer half holding the line (line index bit 0)
- ovf  out  2  sticky per-channel overflow flag
- ovf_cnt0 / ovf_cnt1  out  16  per-channel overflow count (see Configuration)

## Operation
- Per channel, a 22-bit counter cnt: [3:0] is the word within the line, [21:4] is the line index.
- On ien, cnt[3:0] increments.
- At cnt[3:0]==0xF with ien, a line completes:
  - cnt[3:0] goes to 0;
  - line index goes to 0 if it equals size−1, else it increments;
  - on wrap, bcnt increments by 1 (32-bit wrap).
- size==0 behaves as 2^18 lines (size−1 is computed in 18 bits).
- On line completion the channel latches:
  - addr = {base[31:6] + line_index_before_increment, 6'b0} (26-bit add, carry dropped);
  - half = line_index[0];
  - it then sets pending.
- If pending is already set and not being accepted that cycle: overflow.
  - The new line is dropped and the older descriptor is kept.
  - ovf[ch] is set.
  - The overflow counter increments.
- Arbiter states:
  - IDLE: no descriptor presented. When any pending bit is set, select a channel and go to OFFER. If both are pending, select the channel ≠ last_grant.
  - OFFER: desc_valid=1 with addr/ch/half stable. On desc_ready, clear that channel's pending, set last_grant=ch and return to IDLE.
- Accept and a new completion on the same channel in the same cycle: pending stays set with the new descriptor; no overflow.
- sync has priority over ien in the same cycle. It clears:
  - cnt, bcnt, pending and last_grant (to 1, so ch0 is favoured first);
  - the arbiter state (to IDLE).
  - ovf and ovf_cnt are NOT cleared by sync; only rst clears them.
- sync during OFFER: desc_valid drops the next cycle. The writer must tolerate withdrawal on sync.

## Timing
- Reset values: iaddr*=0, iacnt*=0, bcnt*=0, desc_valid=0, desc_addr=0, desc_ch=0, desc_half=0, ovf=0, ovf_cnt*=0, last_grant=1, state IDLE.
- Outputs are registered.
- Completion edge at cycle N: pending visible at N+1, desc_valid=1 at N+2 (minimum latency).
- Back-to-back accepts: one descriptor per 2 cycles (IDLE/OFFER alternate).
- Minimum line period is 16 cycles per channel, so two channels never overflow when desc_ready is held high.

## Configuration
- S2A_SCHED_OVF_CNT_EN defined: ovf_cnt0/1 are 16-bit saturating counters (hold at 0xFFFF), cleared only by rst.
- Not defined: counters are not built and ovf_cnt0/1 read constant 0. The sticky ovf flags remain.

## Test plan
- rst, base0=0x1000_0000, size0=4, ien0 high for 64 cycles, desc_ready=1 -> descriptors 0x1000_0000, 0x1000_0040, 0x1000_0080, 0x1000_00C0; halves 0,1,0,1; bcnt0=1; iacnt0=0.
- Both channels complete in the same cycle, last_grant reset value -> ch0 granted first, then ch1; the next simultaneous pair is also granted ch0 then ch1.
- desc_ready=0, ch0 completes 2 lines -> one descriptor held stable, ovf[0]=1, ovf_cnt0=1 (macro on) or 0 (macro off); release ready -> the first line's address is issued.
- Accept and a new ch1 completion in the same cycle -> next descriptor is ch1 with the new address, ovf[1]=0.
- sync asserted with ien0 high while in OFFER -> cnt0=0, bcnt0=0, desc_valid=0 the next cycle, ovf unchanged.
- base1=0xFFFF_FFC0, size1=2 -> second descriptor address 0x0000_0000 (carry dropped).

Source files
------------

// File: rtl/s2a_burst_sched.sv
// Two-channel stream-side burst scheduler: ring line counters, ping-pong buffer addressing and a
// round-robin descriptor arbiter. Optional macro S2A_SCHED_OVF_CNT_EN builds saturating overflow counters.
module s2a_burst_sched (
  input  logic        Sclk,
  input  logic        rst,
  input  logic        sync,
  input  logic        ien0,
  input  logic        ien1,
  input  logic [31:0] base0,
  input  logic [31:0] base1,
  input  logic [17:0] size0,
  input  logic [17:0] size1,
  output logic [4:0]  iaddr0,
  output logic [4:0]  iaddr1,
  output logic [17:0] iacnt0,
  output logic [17:0] iacnt1,
  output logic [31:0] bcnt0,
  output logic [31:0] bcnt1,
  output logic        desc_valid,
  input  logic        desc_ready,
  output logic [31:0] desc_addr,
  output logic        desc_ch,
  output logic        desc_half,
  output logic [1:0]  ovf,
  output logic [15:0] ovf_cnt0,
  output logic [15:0] ovf_cnt1,
  output logic        state_dbg
);

  // Handshake: a descriptor transfers on a rising Sclk edge where desc_valid and desc_ready are both
  // high; desc_addr/desc_ch/desc_half are held while desc_valid is high, but sync may withdraw it.
  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t            state, state_nx;
  logic              last_grant;
  logic              sel_nx;
  logic              load;

  logic [1:0]        ien_v;
  logic [1:0][31:0]  base_v;
  logic [1:0][17:0]  size_v;
  logic [1:0][21:0]  cnt;
  logic [1:0][31:0]  bcnt;
  logic [1:0]        pend;
  logic [1:0][31:0]  p_addr;
  logic [1:0]        p_half;
  logic [1:0]        done;
  logic [1:0]        accept;
  logic [1:0]        last_line;
  logic [1:0]        overflow;
  logic [1:0][31:0]  line_addr;

  assign ien_v  = {ien1, ien0};
  assign base_v = {base1, base0};
  assign size_v = {size1, size0};

  always_comb begin
    done      = '0;
    accept    = '0;
    last_line = '0;
    overflow  = '0;
    line_addr = '0;
    for (int i = 0; i < 2; i++) begin
      done[i]      = ien_v[i] && (cnt[i][3:0] == 4'hF) && !sync;
      accept[i]    = (state == OFFER) && desc_ready && (desc_ch == 1'(i)) && !sync;
      // size-1 wraps in 18 bits, so size 0 means a full 2^18-line ring
      last_line[i] = (cnt[i][21:4] == (size_v[i] - 18'd1));
      line_addr[i] = {base_v[i][31:6] + {8'd0, cnt[i][21:4]}, 6'd0};
      overflow[i]  = done[i] && pend[i] && !accept[i];
    end
  end

  always_ff @(posedge Sclk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      bcnt   <= '0;
      pend   <= '0;
      p_addr <= '0;
      p_half <= '0;
    end else if (sync) begin
      cnt  <= '0;
      bcnt <= '0;
      pend <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (accept[i]) pend[i] <= 1'b0;
        // a completion landing on the accept cycle refills the slot instead of overflowing
        if (done[i] && (!pend[i] || accept[i])) begin
          pend[i]   <= 1'b1;
          p_addr[i] <= line_addr[i];
          p_half[i] <= cnt[i][4];
        end
        if (ien_v[i]) begin
          if (cnt[i][3:0] == 4'hF) begin
            cnt[i] <= last_line[i] ? 22'd0 : {cnt[i][21:4] + 18'd1, 4'd0};
            if (last_line[i]) bcnt[i] <= bcnt[i] + 32'd1;
          end else begin
            cnt[i] <= cnt[i] + 22'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge Sclk or posedge rst) begin
    if (rst) ovf <= '0;
    else     ovf <= ovf | overflow;
  end

`ifdef S2A_SCHED_OVF_CNT_EN
  logic [1:0][15:0] ovf_cnt_q;

  always_ff @(posedge Sclk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (overflow[i] && (ovf_cnt_q[i] != 16'hFFFF)) ovf_cnt_q[i] <= ovf_cnt_q[i] + 16'd1;
    end
  end

  assign ovf_cnt0 = ovf_cnt_q[0];
  assign ovf_cnt1 = ovf_cnt_q[1];
`else
  assign ovf_cnt0 = 16'd0;
  assign ovf_cnt1 = 16'd0;
`endif

  always_comb begin
    state_nx = state;
    sel_nx   = 1'b0;
    load     = 1'b0;
    if (sync) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (|pend) begin
            load     = 1'b1;
            state_nx = OFFER;
            sel_nx   = (pend == 2'b11) ? ~last_grant : pend[1];
          end
        end
        OFFER: begin
          if (desc_ready) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge Sclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      desc_addr  <= '0;
      desc_ch    <= 1'b0;
      desc_half  <= 1'b0;
    end else begin
      state <= state_nx;
      if (sync)        last_grant <= 1'b1;
      else if (|accept) last_grant <= desc_ch;
      if (load) begin
        desc_addr <= p_addr[sel_nx];
        desc_ch   <= sel_nx;
        desc_half <= p_half[sel_nx];
      end
    end
  end

  assign desc_valid = (state == OFFER);
  assign state_dbg  = state;
  assign iaddr0     = cnt[0][4:0];
  assign iaddr1     = cnt[1][4:0];
  assign iacnt0     = cnt[0][21:4];
  assign iacnt1     = cnt[1][21:4];
  assign bcnt0      = bcnt[0];
  assign bcnt1      = bcnt[1];

endmodule

// File: tb/tb_s2a_burst_sched.sv
// Bench for s2a_burst_sched: directed scenarios plus randomized traffic checked against a
// word-count/queue model of the scheduler.
module tb_s2a_burst_sched;

  logic        Sclk = 1'b0;
  logic        rst = 1'b1;
  logic        sync = 1'b0;
  logic        ien0 = 1'b0, ien1 = 1'b0;
  logic [31:0] base0 = '0, base1 = '0;
  logic [17:0] size0 = '0, size1 = '0;
  logic [4:0]  iaddr0, iaddr1;
  logic [17:0] iacnt0, iacnt1;
  logic [31:0] bcnt0, bcnt1;
  logic        desc_valid;
  logic        desc_ready = 1'b0;
  logic [31:0] desc_addr;
  logic        desc_ch, desc_half;
  logic [1:0]  ovf;
  logic [15:0] ovf_cnt0, ovf_cnt1;
  logic        state_dbg;

  s2a_burst_sched dut (
    .Sclk(Sclk), .rst(rst), .sync(sync), .ien0(ien0), .ien1(ien1),
    .base0(base0), .base1(base1), .size0(size0), .size1(size1),
    .iaddr0(iaddr0), .iaddr1(iaddr1), .iacnt0(iacnt0), .iacnt1(iacnt1),
    .bcnt0(bcnt0), .bcnt1(bcnt1), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_addr(desc_addr), .desc_ch(desc_ch), .desc_half(desc_half), .ovf(ovf),
    .ovf_cnt0(ovf_cnt0), .ovf_cnt1(ovf_cnt1), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 Sclk = ~Sclk;

  int checks = 0;
  int errors = 0;

  // model: words written since last sync, outstanding descriptors per channel ({half, addr})
  longint      words [2];
  logic [31:0] mbase [2];
  logic [17:0] msz [2];
  logic [1:0]  movf = '0;
  int          movf_cnt [2];
  logic [32:0] exp_q [2][$];
  logic [33:0] acc_log [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint lines_of(input logic [17:0] s);
    return (s == 18'd0) ? 64'd262144 : 64'(s);
  endfunction

  task automatic check_outputs();
    longint lt, idx, b;
    logic [4:0]  e_iaddr [2];
    logic [17:0] e_iacnt [2];
    logic [31:0] e_bcnt [2];
    for (int c = 0; c < 2; c++) begin
      lt = words[c] / 16;
      idx = lt % lines_of(msz[c]);
      b = lt / lines_of(msz[c]);
      e_iaddr[c] = {idx[0], 4'(words[c] % 16)};
      e_iacnt[c] = idx[17:0];
      e_bcnt[c] = b[31:0];
    end
    check("iaddr0", 64'(iaddr0), 64'(e_iaddr[0]));
    check("iaddr1", 64'(iaddr1), 64'(e_iaddr[1]));
    check("iacnt0", 64'(iacnt0), 64'(e_iacnt[0]));
    check("iacnt1", 64'(iacnt1), 64'(e_iacnt[1]));
    check("bcnt0", 64'(bcnt0), 64'(e_bcnt[0]));
    check("bcnt1", 64'(bcnt1), 64'(e_bcnt[1]));
    check("ovf", 64'(ovf), 64'(movf));
`ifdef S2A_SCHED_OVF_CNT_EN
    check("ovf_cnt0", 64'(ovf_cnt0), 64'(movf_cnt[0]));
    check("ovf_cnt1", 64'(ovf_cnt1), 64'(movf_cnt[1]));
`else
    check("ovf_cnt0", 64'(ovf_cnt0), 64'(0));
    check("ovf_cnt1", 64'(ovf_cnt1), 64'(0));
`endif
    if (exp_q[0].size() == 0 && exp_q[1].size() == 0)
      check("valid_idle", 64'(desc_valid), 64'(0));
  endtask

  // driver: one cycle of stimulus applied at a negedge, model advanced, outputs checked next negedge
  task automatic step(input logic e0, input logic e1, input logic rdy, input logic sy);
    logic [32:0] got, d;
    logic [1:0]  e;
    longint      k, idx;
    int          c;
    ien0 = e0; ien1 = e1; desc_ready = rdy; sync = sy;
    base0 = mbase[0]; base1 = mbase[1]; size0 = msz[0]; size1 = msz[1];
    e = {e1, e0};
    if (sy) begin
      words[0] = 0; words[1] = 0;
      exp_q[0].delete(); exp_q[1].delete();
    end else begin
      if (desc_valid && rdy) begin
        c = int'(desc_ch);
        got = {desc_half, desc_addr};
        check("desc_pending", 64'(exp_q[c].size() != 0), 64'(1));
        if (exp_q[c].size() != 0) begin
          d = exp_q[c].pop_front();
          check(c == 0 ? "desc0" : "desc1", 64'(got), 64'(d));
        end
        acc_log.push_back({desc_ch, got});
      end
      for (int i = 0; i < 2; i++) begin
        if (e[i]) begin
          words[i]++;
          if (words[i] % 16 == 0) begin
            k = words[i] / 16 - 1;
            idx = k % lines_of(msz[i]);
            d = {idx[0], mbase[i][31:6] + 26'(idx), 6'd0};
            if (exp_q[i].size() != 0) begin
              movf[i] = 1'b1;
              if (movf_cnt[i] < 65535) movf_cnt[i]++;
            end else begin
              exp_q[i].push_back(d);
            end
          end
        end
      end
    end
    @(negedge Sclk);
    check_outputs();
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 20; n++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && !desc_valid) break;
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end
    check({tag, "_drained"}, 64'(exp_q[0].size() + exp_q[1].size()), 64'(0));
  endtask

  task automatic do_sync(input logic [31:0] b0, input logic [17:0] s0,
                         input logic [31:0] b1, input logic [17:0] s1);
    mbase[0] = b0; msz[0] = s0; mbase[1] = b1; msz[1] = s1;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    acc_log.delete();
  endtask

  logic [31:0] t1_exp [4];
  logic [31:0] a0;
  logic        r;

  initial begin
    words[0] = 0; words[1] = 0; movf_cnt[0] = 0; movf_cnt[1] = 0;
    mbase[0] = '0; mbase[1] = '0; msz[0] = '0; msz[1] = '0;
    repeat (2) @(negedge Sclk);
    check("rst_desc_valid", 64'(desc_valid), 64'(0));
    check("rst_desc_addr", 64'(desc_addr), 64'(0));
    check("rst_desc_ch", 64'(desc_ch), 64'(0));
    check("rst_desc_half", 64'(desc_half), 64'(0));
    check("rst_state", 64'(state_dbg), 64'(0));
    check_outputs();
    rst = 1'b0;

    // ring of 4 lines on ch0, ready held high
    do_sync(32'h1000_0000, 18'd4, 32'h2000_0000, 18'd8);
    for (int i = 1; i <= 64; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      if (i == 16) check("lat_n1", 64'(desc_valid), 64'(0));
      if (i == 17) check("lat_n2", 64'(desc_valid), 64'(1));
    end
    drain("t1");
    t1_exp[0] = 32'h1000_0000; t1_exp[1] = 32'h1000_0040;
    t1_exp[2] = 32'h1000_0080; t1_exp[3] = 32'h1000_00C0;
    check("t1_count", 64'(acc_log.size()), 64'(4));
    for (int i = 0; i < 4 && i < acc_log.size(); i++) begin
      check("t1_addr", 64'(acc_log[i][31:0]), 64'(t1_exp[i]));
      check("t1_half", 64'(acc_log[i][32]), 64'(i % 2));
    end
    check("t1_bcnt0", 64'(bcnt0), 64'(1));
    check("t1_iacnt0", 64'(iacnt0), 64'(0));

    // simultaneous completions, twice
    do_sync(32'h1000_0000, 18'd4, 32'h2000_0000, 18'd8);
    repeat (2) begin
      repeat (16) step(1'b1, 1'b1, 1'b1, 1'b0);
      drain("t2");
    end
    check("t2_count", 64'(acc_log.size()), 64'(4));
    for (int i = 0; i < 4 && i < acc_log.size(); i++)
      check("t2_order", 64'(acc_log[i][33]), 64'(i % 2));

    // overflow on ch0 with ready low
    do_sync(32'h3000_0000, 18'd4, 32'h2000_0000, 18'd8);
    repeat (32) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_valid", 64'(desc_valid), 64'(1));
    check("t3_held_addr", 64'(desc_addr), 64'(32'h3000_0000));
    check("t3_ovf0", 64'(ovf[0]), 64'(1));
    drain("t3");
    check("t3_count", 64'(acc_log.size()), 64'(1));
    if (acc_log.size() != 0) check("t3_addr", 64'(acc_log[0][31:0]), 64'(32'h3000_0000));

    // accept and new ch1 completion in the same cycle
    do_sync(32'h3000_0000, 18'd4, 32'h4000_0000, 18'd8);
    repeat (31) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    drain("t4");
    check("t4_count", 64'(acc_log.size()), 64'(2));
    if (acc_log.size() == 2) begin
      check("t4_ch", 64'(acc_log[1][33]), 64'(1));
      check("t4_addr", 64'(acc_log[1][31:0]), 64'(32'h4000_0040));
    end
    check("t4_ovf1", 64'(ovf[1]), 64'(0));

    // sync while offering
    do_sync(32'h3000_0000, 18'd4, 32'h4000_0000, 18'd8);
    repeat (18) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t5_offer", 64'(desc_valid), 64'(1));
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("t5_valid", 64'(desc_valid), 64'(0));
    check("t5_iacnt0", 64'(iacnt0), 64'(0));
    check("t5_ovf", 64'(ovf), 64'(2'b01));

    // 26-bit address carry dropped
    do_sync(32'h3000_0000, 18'd4, 32'hFFFF_FFC0, 18'd2);
    repeat (32) step(1'b0, 1'b1, 1'b1, 1'b0);
    drain("t6");
    check("t6_count", 64'(acc_log.size()), 64'(2));
    if (acc_log.size() == 2) begin
      check("t6_addr0", 64'(acc_log[0][31:0]), 64'(32'hFFFF_FFC0));
      check("t6_addr1", 64'(acc_log[1][31:0]), 64'(32'h0000_0000));
    end

    // randomized traffic
    do_sync($urandom, 18'($urandom_range(0, 5)), $urandom, 18'($urandom_range(1, 5)));
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 299) == 0);
      if (r) begin
        a0 = $urandom;
        mbase[0] = a0;
        mbase[1] = $urandom;
        msz[0] = 18'($urandom_range(1, 6));
        msz[1] = 18'($urandom_range(0, 6));
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0) || (n % 64 > 40), r);
    end
    drain("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
